// File: rtl/kernel_stream_pkg.sv
// kernel_stream_pkg: shared types and helpers for the kernel stream sink.
package kernel_stream_pkg;
    localparam int STREAMW_DEF = 32;

    typedef struct packed {
        logic                   valid;
        logic [STREAMW_DEF-1:0] data;
    } beat_t;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/stream_sync_fifo.sv
// stream_sync_fifo: show-ahead synchronous FIFO with occupancy output.
module stream_sync_fifo
    import kernel_stream_pkg::*;
#(
    parameter int W     = STREAMW_DEF,
    parameter int DEPTH = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  occ
);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Head is masked while empty so stale storage never shows on the drain port.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign occ   = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/kernel_stream_sink.sv
// kernel_stream_sink: buffers a kernel's latency-1 output stream for a drain port
// and keeps run statistics (count, checksum, done, overflow).
module kernel_stream_sink
    import kernel_stream_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEF,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int NWORDS  = 1024,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] in1_s0,
    output logic               iready,
    output logic               ovalid,
    output logic [STREAMW-1:0] out1_s0,
    input  logic               oready,
    input  logic               start,
    output logic [CNTW-1:0]    count,
    output logic [STREAMW-1:0] checksum,
    output logic               done,
    output logic               overflow
);
    logic               full, empty, pop, push, drop;
    logic [AW:0]        occ, occ_next;
    logic [CNTW-1:0]    cnt_next;
    logic [STREAMW-1:0] cs_next;

    stream_sync_fifo #(.W(STREAMW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (in1_s0),
        .dout  (out1_s0),
        .full  (full),
        .empty (empty),
        .occ   (occ)
    );

    // Upstream ignores iready for one cycle, so a full FIFO can only take a beat if it drains.
    assign ovalid   = !empty;
    assign pop      = ovalid && oready;
    assign push     = ivalid && (!full || pop);
    assign drop     = ivalid && full && !pop;
    assign occ_next = occ + (AW+1)'(push) - (AW+1)'(pop);
    assign cnt_next = (start ? '0 : count) + CNTW'(push);
    assign cs_next  = (start ? '0 : checksum) + (push ? in1_s0 : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            iready   <= 1'b0;
            count    <= '0;
            checksum <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            iready   <= (occ_next <= (AW+1)'(DEPTH - 2));
            count    <= cnt_next;
            checksum <= cs_next;
            done     <= (!start && done) || (push && cnt_next == CNTW'(NWORDS));
            overflow <= (!start && overflow) || drop;
        end
    end
endmodule

// File: tb/tb_kernel_stream_sink.sv
// tb_kernel_stream_sink: directed scoreboard bench for kernel_stream_sink (DEPTH=8, NWORDS=4).
module tb_kernel_stream_sink;
    import kernel_stream_pkg::*;
    localparam int NW = 4;

    logic        clk = 1'b0, rstn = 1'b0, ivalid = 1'b0, oready = 1'b0, start = 1'b0;
    logic [31:0] in1_s0 = '0;
    logic        iready, ovalid, done, overflow;
    logic [31:0] out1_s0, count, checksum;

    int          total = 0, bad = 0;
    logic [31:0] q[$];
    logic [31:0] m_cnt = '0, m_cs = '0;
    logic        m_done = 1'b0, m_ovf = 1'b0, m_rdy = 1'b0, prev;

    kernel_stream_sink #(.STREAMW(32), .DEPTH(8), .AW(3), .NWORDS(NW), .CNTW(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ivalid   (ivalid),
        .in1_s0   (in1_s0),
        .iready   (iready),
        .ovalid   (ovalid),
        .out1_s0  (out1_s0),
        .oready   (oready),
        .start    (start),
        .count    (count),
        .checksum (checksum),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check drain side, advance the model, take the edge, check statistics.
    task automatic cyc();
        bit pop, acc, drop;
        chk("ovalid", ovalid, 32'(q.size() != 0));
        if (q.size() != 0) chk("head", out1_s0, q[0]);
        pop  = oready && q.size() != 0;
        acc  = ivalid && (q.size() < 8 || pop);
        drop = ivalid && q.size() == 8 && !pop;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(in1_s0);
        if (start) begin
            m_cnt = '0; m_cs = '0; m_done = 1'b0; m_ovf = 1'b0;
        end
        if (acc) begin
            m_cnt++;
            m_cs += in1_s0;
            if (m_cnt == NW) m_done = 1'b1;
        end
        m_ovf |= drop;
        m_rdy = (8 - q.size()) >= 2;
        @(posedge clk);
        #1;
        chk("count", count, m_cnt);
        chk("checksum", checksum, m_cs);
        chk("done", done, 32'(m_done));
        chk("overflow", overflow, 32'(m_ovf));
        chk("iready", iready, 32'(m_rdy));
    endtask

    initial begin
        #3;
        chk("rst_iready", iready, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_out", out1_s0, 0);
        chk("rst_count", count, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        chk("rel_iready", iready, 1);
        // Fill with oready low; upstream follows iready one cycle late.
        start = 1'b1; cyc(); start = 1'b0;
        in1_s0 = 32'h10;
        for (int i = 0; i < 12; i++) begin
            prev = iready;
            cyc();
            ivalid = prev;
            in1_s0 = in1_s0 + 32'd1;
        end
        ivalid = 1'b0;
        chk("fill_iready", iready, 0);
        chk("fill_overflow", overflow, 0);
        chk("fill_ovalid", ovalid, 1);
        // Forced beat into a full FIFO is dropped.
        ivalid = 1'b1; in1_s0 = 32'hDEAD;
        cyc();
        ivalid = 1'b0;
        chk("drop_overflow", overflow, 1);
        chk("drop_count", count, 8);
        cyc();
        // Full FIFO with simultaneous push and pop.
        start = 1'b1; cyc(); start = 1'b0;
        ivalid = 1'b1; oready = 1'b1; in1_s0 = 32'h100;
        cyc();
        ivalid = 1'b0;
        chk("pp_overflow", overflow, 0);
        chk("pp_count", count, 1);
        repeat (10) cyc();
        // Push 1..4 and drain freely.
        start = 1'b1; cyc(); start = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            ivalid = 1'b1; in1_s0 = 32'(v);
            cyc();
        end
        ivalid = 1'b0;
        chk("seq_count", count, 4);
        chk("seq_checksum", checksum, 10);
        chk("seq_done", done, 1);
        repeat (3) cyc();
        // Checksum wrap, then start with a concurrent beat.
        start = 1'b1; cyc(); start = 1'b0;
        ivalid = 1'b1; in1_s0 = 32'hFFFF_FFFF; cyc();
        in1_s0 = 32'h2; cyc();
        ivalid = 1'b0;
        chk("wrap_checksum", checksum, 1);
        start = 1'b1; ivalid = 1'b1; in1_s0 = 32'h5;
        cyc();
        start = 1'b0; ivalid = 1'b0;
        chk("st_count", count, 1);
        chk("st_checksum", checksum, 5);
        chk("st_done", done, 0);
        repeat (3) cyc();
        // Reset mid-stream with five entries buffered.
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ivalid = 1'b1; in1_s0 = 32'hA0 + 32'(i);
            cyc();
        end
        ivalid = 1'b0;
        chk("mid_ovalid_pre", ovalid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_iready", iready, 0);
        chk("mid_ovalid", ovalid, 0);
        chk("mid_out", out1_s0, 0);
        chk("mid_count", count, 0);
        chk("mid_checksum", checksum, 0);
        chk("mid_done", done, 0);
        chk("mid_overflow", overflow, 0);
        q.delete();
        m_cnt = '0; m_cs = '0; m_done = 1'b0; m_ovf = 1'b0; m_rdy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        chk("mid_rel_iready", iready, 1);
        chk("mid_rel_ovalid", ovalid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/kernel_stream_sink.md
# kernel_stream_sink

Terminal consumer for a kernel leaf node's output stream: accepts the kernel's registered `out1_s0`/`ovalid` beats, buffers them in a small FIFO, and presents them to a drain port (host/memory writer). The kernel's `ovalid` follows its `ivalid` one cycle later and ignores back-pressure, so this sink must still absorb one in-flight beat after dropping ready. It also keeps a beat count, a wrapping checksum and a done flag for run completion.

## Interface
- `STREAMW`, 32, data width of each beat
- `DEPTH`, 8, FIFO entries; power of two, ≥4
- `AW`, 3, log2(DEPTH)
- `NWORDS`, 1024, beats expected per run; `done` asserts when reached
- `CNTW`, 32, width of `count`

- `clk` input 1: single clock
- `rstn` input 1: reset, asynchronous, active-low
- `ivalid` input 1: beat valid from kernel (kernel `ovalid`)
- `in1_s0` input STREAMW: beat data from kernel (kernel `out1_s0`)
- `iready` output 1: back-pressure to kernel (drives kernel `oready`), registered
- `ovalid` output 1: drain beat valid
- `out1_s0` output STREAMW: drain beat data (FIFO head)
- `oready` input 1: drain consumer ready
- `start` input 1: one-cycle pulse, clears run statistics
- `count` output CNTW: beats accepted since last `start`/reset
- `checksum` output STREAMW: wrapping sum of accepted beats
- `done` output 1: sticky, `count` reached NWORDS
- `overflow` output 1: sticky, a beat was dropped

## Operation
- Push: `ivalid` high is a beat, independent of `iready` (upstream latency-1 skid). Accepted if FIFO not full, or full and a pop occurs the same cycle.
- Dropped beat (`ivalid` high, full, no pop): data discarded, `overflow` set, `count`/`checksum` unchanged.
- Pop: `ovalid && oready`. `ovalid = !empty`; `out1_s0` = head entry (show-ahead), stable while `ovalid && !oready`.
- Push and pop same cycle: occupancy unchanged; empty FIFO push+pop impossible (pop needs `ovalid`).
- `iready` next = (DEPTH − occ_next) ≥ 2, where occ_next is occupancy after this cycle's push/pop. Guarantees one skid slot.
- Accepted beat: `count += 1` (wraps at 2^CNTW), `checksum += in1_s0` mod 2^STREAMW.
- `done` sets on the cycle `count` becomes NWORDS; beats after done still accepted and counted; `done` stays high.
- `start`: synchronous clear of `count`, `checksum`, `done`, `overflow`; FIFO contents and pointers untouched. `start` with an accepted beat same cycle: `count`=1, `checksum`=that beat.

## Timing
- Reset (async assert, sync release): `iready`=0, `ovalid`=0, `out1_s0`=0, `count`=0, `checksum`=0, `done`=0, `overflow`=0, FIFO empty. `iready`=1 on first rising edge after release.
- Reset mid-run: all above immediately; FIFO contents lost.
- Push-to-`ovalid` latency: 1 cycle (beat accepted at edge N visible on drain after edge N).
- `count`/`checksum`/`done` update at the edge that accepts the beat.
- `iready` changes 1 cycle after the occupancy change that causes it.
- Pointers AW+1 bits; full = MSBs differ and low bits equal; wrap-around seamless.

## Structure
- Shared package `kernel_stream_pkg`: default STREAMW, handshake beat type, `clog2` helper.
- One sub-module: `stream_sync_fifo` (show-ahead, occupancy output, push/pop/full/empty); sink top holds `iready` logic, statistics, sticky flags.

## Test plan
- DEPTH=8, `oready`=0, `ivalid` held high, upstream honouring `iready` with 1-cycle lag: `iready` falls after occupancy 7 is registered, skid beat lands, final occupancy 8, `overflow`=0.
- Push 1,2,3,4 with NWORDS=4, drain freely: drain emits 1,2,3,4 in order; `count`=4, `checksum`=10, `done`=1 on 4th accept edge.
- Full FIFO, `oready`=0, force `ivalid`=1 with 0xDEAD: `overflow`=1, `count` unchanged, 0xDEAD never drained.
- Full FIFO, `ivalid`=1 and `oready`=1 same cycle: beat accepted, head popped, occupancy stays 8, `overflow`=0.
- `checksum` wrap: push 0xFFFFFFFF then 0x2 → `checksum`=0x1; `start` pulse with concurrent beat 0x5 → `count`=1, `checksum`=0x5, `done`=0.
- Deassert `rstn` mid-stream with 5 entries: outputs zero asynchronously; after release FIFO empty, `iready`=1 next edge.
